// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory load/fetch block.
package imem_pkg;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  localparam int INSTR_W = 32;

  // A byte address is usable when it is word aligned and its word index fits in 2**aw words.
  function automatic logic addr_ok(input logic [31:0] addr, input int aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_dbg_arbiter.sv
// Fetch/debug write arbitration. Fetch normally wins a tie, but a debug write
// that has lost STARVE_LIMIT consecutive ties is forced through on the next one.
module imem_dbg_arbiter
  import imem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  input  logic   f_req,
  input  logic   dbg_we,
  output logic   dbg_grant,
  output logic   f_block
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_reg;
  logic          run;
  logic          forced;

  assign run       = (state == ST_RUN);
  assign forced    = (starve_cnt_reg == CW'(STARVE_LIMIT));
  assign dbg_grant = run & dbg_we & (~f_req | forced);
  // Fetch loses only when it collides with a granted debug write.
  assign f_block   = f_req & dbg_grant;

  // Count consecutive lost ties; any debug grant clears the history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
    end else if (dbg_grant) begin
      starve_cnt_reg <= '0;
    end else if (run & f_req & dbg_we) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/imem_load_arbiter.sv
// Instruction-word storage with a boot-time load sequencer, single-cycle-latency
// fetch port and an arbitrated debug write port.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          ld_skip,
  output logic          ld_ready,
  output logic          load_done,
  output logic [AW:0]   word_count,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_valid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  output logic          f_stall,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_ack
);

  logic [INSTR_W-1:0] mem [DEPTH];

  state_t             state_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW:0]        word_count_reg;
  logic               ld_ready_reg;
  logic [INSTR_W-1:0] rd_data_reg;
  logic               f_valid_reg;
  logic               f_err_reg;

  logic               run;
  logic               ld_fire;
  logic               dbg_grant;
  logic               f_block;
  logic               f_accept;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;

  imem_dbg_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .state     (state_reg),
    .f_req     (f_req),
    .dbg_we    (dbg_we),
    .dbg_grant (dbg_grant),
    .f_block   (f_block)
  );

  assign run      = (state_reg == ST_RUN);
  // Skip has priority over a word offered in the same cycle.
  assign ld_fire  = (state_reg == ST_LOAD) & ld_ready_reg & ld_valid & ~ld_skip;
  assign f_accept = run & f_req & ~f_block;

  // Loader and debug writes never coexist: the loader only writes in LOAD, debug only in RUN.
  // Faulty debug addresses are still acked, but the write is dropped.
  assign mem_we    = ld_fire | (dbg_grant & addr_ok(dbg_addr, AW));
  assign mem_waddr = run ? dbg_addr[AW+1:2] : wr_ptr_reg;
  assign mem_wdata = run ? dbg_wdata : ld_data;

  assign ld_ready   = ld_ready_reg;
  assign load_done  = run;
  assign word_count = word_count_reg;
  assign dbg_ack    = dbg_grant;
  // Every fetch stalls during LOAD; the reset term keeps the output quiet while held in reset.
  assign f_stall    = rst & (run ? f_block : f_req);
  assign f_valid    = f_valid_reg;
  assign f_err      = f_err_reg;
  assign f_rdata    = (f_valid_reg & ~f_err_reg) ? rd_data_reg : '0;

  // Storage: one write port, registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_reg <= mem[f_addr[AW+1:2]];
  end

  // Load sequencer and fetch response qualifiers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_LOAD;
      wr_ptr_reg     <= '0;
      word_count_reg <= '0;
      ld_ready_reg   <= 1'b0;
      f_valid_reg    <= 1'b0;
      f_err_reg      <= 1'b0;
    end else begin
      f_valid_reg <= f_accept;
      f_err_reg   <= f_accept & ~addr_ok(f_addr, AW);
      case (state_reg)
        ST_LOAD: begin
          if (ld_skip) begin
            state_reg    <= ST_RUN;
            ld_ready_reg <= 1'b0;
          end else begin
            ld_ready_reg <= 1'b1;
            if (ld_fire) begin
              wr_ptr_reg     <= wr_ptr_reg + 1'b1;
              word_count_reg <= word_count_reg + 1'b1;
              if (ld_last || (wr_ptr_reg == AW'(DEPTH - 1))) begin
                state_reg    <= ST_RUN;
                ld_ready_reg <= 1'b0;
              end
            end
          end
        end
        ST_RUN: begin
          ld_ready_reg <= 1'b0;
        end
        default: begin
          state_reg    <= ST_LOAD;
          ld_ready_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the instruction-word storage.
- Sequences a boot-time program load from an external loader stream, then serves single-cycle-latency core fetches.
- In RUN, arbitrates between fetch reads and a debug write port, with an anti-starvation counter.
- Sits between the boot loader (UART/JTAG bridge), the fetch stage and the debug unit.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words (power of two).
- AW, 10, word-index width, log2(DEPTH).
- STARVE_LIMIT, 4, consecutive cycles a pending debug write may lose to fetch before it is forced through.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- ld_valid  input  1  loader word valid.
- ld_data  input  32  loader instruction word.
- ld_last  input  1  marks final loader word.
- ld_skip  input  1  leave LOAD immediately, keep current contents.
- ld_ready  output  1  loader word accepted this cycle when ld_valid=1.
- load_done  output  1  high in RUN.
- word_count  output  AW+1  words written during the last LOAD.
- f_req  input  1  fetch request.
- f_addr  input  32  fetch byte address.
- f_valid  output  1  fetch response valid.
- f_rdata  output  32  fetched instruction.
- f_err  output  1  fetch fault (misaligned/out of range), qualified by f_valid.
- f_stall  output  1  fetch request not accepted this cycle.
- dbg_we  input  1  debug write request, held until acked.
- dbg_addr  input  32  debug byte address.
- dbg_wdata  input  32  debug write data.
- dbg_ack  output  1  debug write performed this cycle.

Behaviour:
- Reset (rst=0, async):
  - State LOAD; wr_ptr=0, word_count=0, starve_cnt=0.
  - Outputs: ld_ready=0, load_done=0, f_valid=0, f_rdata=0, f_err=0, f_stall=0, dbg_ack=0.
  - Memory contents are not cleared.
- State LOAD:
  - ld_ready=1 (registered, asserted from the first cycle after reset release).
  - Handshake ld_valid&ld_ready writes mem[wr_ptr]=ld_data; wr_ptr and word_count increment.
  - Transition to RUN on:
    - accepted word with ld_last=1;
    - accepted word at wr_ptr=DEPTH-1 (count=DEPTH);
    - ld_skip=1 (takes priority; no write that cycle).
  - While in LOAD: f_stall=f_req, f_valid=0, dbg_ack=0, dbg writes ignored.
- State RUN (terminal until reset):
  - load_done=1, ld_ready=0.
  - Fetch:
    - Accepted fetch (f_req & ~f_stall) responds next cycle: f_valid=1 and f_rdata=mem[f_addr[AW+1:2]].
    - f_err=1 with f_rdata=0 if f_addr[1:0]!=0 or f_addr[31:AW+2]!=0.
    - Without an accepted fetch: f_valid=0, f_rdata=0.
  - Debug arbitration each cycle:
    - Only fetch or only dbg_we requesting: that requester wins.
    - Both requesting: fetch wins, dbg loses, starve_cnt increments. When starve_cnt==STARVE_LIMIT, dbg wins that cycle and f_stall=1.
    - starve_cnt resets to 0 on every dbg_ack.
    - A debug win writes mem[dbg_addr[AW+1:2]]=dbg_wdata with dbg_ack=1 the same cycle (combinational ack, registered write).
    - Misaligned/out-of-range dbg_addr: acked, write dropped.
  - Read-during-write, same index: fetch is stalled that cycle, so no collision. Fetch reads issued the cycle after the write return the new data.
- Reset asserted mid-load or mid-fetch: all in-flight responses are dropped and the block returns to LOAD with wr_ptr=0.

Decomposition:
- Shared package imem_pkg:
  - state enum {ST_LOAD, ST_RUN};
  - instruction width constant INSTR_W=32;
  - address-check helper function (aligned and in-range).
- One natural sub-module: imem_dbg_arbiter (fetch/debug grant plus starve_cnt). Storage array and load FSM stay in the top.

Test Plan:
- Boot load: release rst, stream 3 words 0xFFC4A303, 0x00832383, 0x0064A423 with ld_last on the third -> word_count=3, load_done=1 the cycle after the third handshake; fetch 0x0,0x4,0x8 returns those words one cycle later, f_err=0.
- Skip: ld_skip=1 in the first LOAD cycle -> RUN next cycle, word_count=0, no writes; fetch before the skip sees f_stall=1.
- Fetch faults: fetch 0x6 and fetch 0x1000 (DEPTH=1024) -> f_valid=1, f_err=1, f_rdata=0.
- Starvation: in RUN hold f_req=1 and dbg_we=1 (addr 0x10, data 0x0062E233) -> fetch wins 4 cycles, 5th cycle dbg_ack=1 and f_stall=1; a later fetch of 0x10 returns 0x0062E233.
- Full load: stream DEPTH words without ld_last -> auto RUN after word 1024, word_count=1024, extra ld_valid not accepted.
- Reset mid-load: assert rst after 2 of 5 words -> outputs at reset values immediately; reload from wr_ptr=0.
